// File: rtl/vga_plot_arbiter_pkg.sv
// vga_pkg: shared constants and types for the VGA pixel-write arbiter.
// Contents:
//   VGA_X_MAX / VGA_Y_MAX : visible raster size of the 160x120 vga_adapter
//   colour_t, BLACK, WHITE: 3-bit RGB colour (one bit per channel)
//   arb_state_t           : arbiter state (ARB = free round-robin, LOCK = burst)
// Optional feature macro used by the top: VGA_ARB_BOUNDS_CHECK_EN.
package vga_pkg;

  localparam int VGA_X_MAX = 160;
  localparam int VGA_Y_MAX = 120;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t WHITE = 3'b111;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: bundles the pixel-source handshake and the adapter-side
// pixel outputs of vga_plot_arbiter.
// Signals:
//   req_valid/req_lock [N_REQ]      : per-source offer and burst-lock request
//   req_x/req_y/req_colour (packed) : per-source pixel, slice i = source i
//   req_ready [N_REQ]               : one-hot or zero grant back to the sources
//   x_out/y_out/colour_out/plot_out : registered write to the vga_adapter
//   owner                           : current or last granted source (debug)
// Modports: master = pixel sources + adapter side, slave = the arbiter.
interface vga_plot_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3
);

  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_lock;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ*Y_W-1:0] req_y;
  logic [N_REQ*C_W-1:0] req_colour;
  logic [N_REQ-1:0]     req_ready;
  logic [X_W-1:0]       x_out;
  logic [Y_W-1:0]       y_out;
  logic [C_W-1:0]       colour_out;
  logic                 plot_out;
  logic [OW-1:0]        owner;

  modport master (
    output req_valid, req_lock, req_x, req_y, req_colour,
    input  req_ready, x_out, y_out, colour_out, plot_out, owner
  );

  modport slave (
    input  req_valid, req_lock, req_x, req_y, req_colour,
    output req_ready, x_out, y_out, colour_out, plot_out, owner
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, reusable by other arbiters.
// Ports:
//   valid [N_REQ] : requesting sources
//   ptr   [PTR_W] : highest-priority index; search goes upward and wraps
//   grant [N_REQ] : one-hot first valid source from ptr, or zero if none
module rr_grant #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single pixel-write port of the 160x120
// vga_adapter between N_REQ pixel sources using round-robin with burst lock.
// Ports:
//   clk    : CLOCK_50, the only clock
//   resetn : asynchronous active-low reset (KEY[3])
//   bus    : vga_plot_arbiter_if.slave (source handshake + adapter outputs)
// Timing: a pixel accepted at edge k appears on x/y/colour with plot_out=1
// during cycle k+1.
// Optional feature: define VGA_ARB_BOUNDS_CHECK_EN to suppress plot_out for
// off-screen pixels (they are still handshaken and update rr/lock state).
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3
) (
  input logic               clk,
  input logic               resetn,
  vga_plot_arbiter_if.slave bus
);

  localparam int OW = $clog2(N_REQ);

  arb_state_t       state;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    grant_idx;
  logic [N_REQ-1:0] rr_vec;
  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] ready;
  logic [X_W-1:0]   sel_x, x_q;
  logic [Y_W-1:0]   sel_y, y_q;
  logic [C_W-1:0]   sel_c, c_q;
  logic             accept;
  logic             do_plot;
  logic             plot_q;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + OW'(1);
  endfunction

  rr_grant #(.N_REQ(N_REQ), .PTR_W(OW)) u_rr_grant (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (rr_vec)
  );

  // Ready is forced low during reset so no source sees a grant that the
  // registers cannot take.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    if (!resetn)
      ready = '0;
    else if (state == LOCK)
      ready = owner_mask & bus.req_valid;
    else
      ready = rr_vec;
  end

  // ready is a subset of req_valid, so any set bit is an accept.
  assign accept = |ready;

  always_comb begin
    grant_idx = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ready[i]) begin
        grant_idx = OW'(i);
        sel_x     = bus.req_x[i*X_W +: X_W];
        sel_y     = bus.req_y[i*Y_W +: Y_W];
        sel_c     = bus.req_colour[i*C_W +: C_W];
      end
    end
  end

`ifdef VGA_ARB_BOUNDS_CHECK_EN
  assign do_plot = accept && (int'(sel_x) < VGA_X_MAX) && (int'(sel_y) < VGA_Y_MAX);
`else
  assign do_plot = accept;
`endif

  // In LOCK the pointer is only moved on release; leaving LOCK needs no
  // accept, so a stalled owner can still hand the port back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ARB;
      rr_ptr  <= '0;
      owner_q <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= C_W'(BLACK);
    end else begin
      plot_q <= do_plot;
      if (do_plot) begin
        x_q <= sel_x;
        y_q <= sel_y;
        c_q <= sel_c;
      end
      case (state)
        ARB: begin
          if (accept) begin
            rr_ptr  <= next_idx(grant_idx);
            owner_q <= grant_idx;
            if (bus.req_lock[grant_idx])
              state <= LOCK;
          end
        end
        LOCK: begin
          if (!bus.req_lock[owner_q]) begin
            state  <= ARB;
            rr_ptr <= next_idx(owner_q);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = c_q;
  assign bus.plot_out   = plot_q;
  assign bus.owner      = owner_q;

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

- Shares the single pixel-write port of the 160x120 `vga_adapter` between `N_REQ` pixel sources, e.g. a line-draw FSM, a screen-clear engine and a sprite painter.
- Each source offers one pixel per cycle with a valid/ready handshake.
- The block picks one source by round-robin and registers the winning pixel onto the adapter's `x`/`y`/`colour`/`plot` inputs.
- A source may lock the grant to draw an uninterrupted burst, such as a full line.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters, 2..8.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `C_W`, 3: colour width (1 bit per channel).

Ports:
- `clk` in 1: single clock, `CLOCK_50`; the only clock.
- `resetn` in 1: asynchronous, active-low reset (`KEY[3]`).
- `req_valid` in `N_REQ`: source i offers a pixel.
- `req_lock` in `N_REQ`: source i asks to keep the grant after the current accept.
- `req_x` in `N_REQ*X_W`: packed x; slice i belongs to source i.
- `req_y` in `N_REQ*Y_W`: packed y.
- `req_colour` in `N_REQ*C_W`: packed colour.
- `req_ready` out `N_REQ`: one-hot or zero; the pixel from source i is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `x_out` out `X_W`: to adapter `x`.
- `y_out` out `Y_W`: to adapter `y`.
- `colour_out` out `C_W`: to adapter `colour`.
- `plot_out` out 1: to adapter `plot`; one-cycle pulse per accepted pixel.
- `owner` out `$clog2(N_REQ)`: index of the current or last granted source, for debug.

## Operation
- **Grant logic.** `req_ready` is combinational from `req_valid`, the round-robin pointer `rr_ptr` and the state. At most one bit of `req_ready` is set. `req_ready[i]` never rises without `req_valid[i]`.
- **State ARB (reset state):**
  - The grant goes to the first valid source searching upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - On an accept from source g: `rr_ptr <= (g+1) mod N_REQ` and `owner <= g`.
  - If `req_lock[g]` is also set in that cycle, the next state is LOCK.
- **State LOCK:**
  - `req_ready = (1 << owner) & req_valid`; all other sources are stalled.
  - The state stays LOCK while `req_lock[owner]` is high, including cycles where `req_valid[owner]` is low.
  - When `req_lock[owner]` is low:
    - If `req_valid[owner]` is set in that cycle, the pixel is still accepted; this is the final burst pixel.
    - The next state is ARB, and `rr_ptr` becomes `owner+1` mod `N_REQ`.
- **Output register:**
  - On every accept, `x_out`/`y_out`/`colour_out` load the granted slices and `plot_out` goes to 1.
  - On cycles with no accept, `plot_out` is 0 and the coordinate/colour registers hold their values.
- **Bounds.** Coordinates are unsigned. A valid pixel has x < 160 and y < 120. Out-of-range handling is set under Configuration.
- **Reset values:** `plot_out`=0, `x_out`=0, `y_out`=0, `colour_out`=0, `owner`=0, `rr_ptr`=0, state ARB.
  - Reset asserted mid-burst drops the lock and any pixel in flight. No partial plot is issued.

## Timing
- **Latency:** accept on rising edge k; `plot_out`=1 with the matching data during cycle k+1. The adapter writes the pixel at edge k+2.
- **Throughput:** one pixel per clock, with no bubble on a grant change and none entering or leaving LOCK.
- **No deadlock from validity:**
  - A source that drops `req_valid` while in ARB loses nothing.
  - A locked source that drops `req_valid` stalls all others until it deasserts `req_lock`. This is a documented source obligation.
- **Simultaneous events:**
  - Lock request and accept in the same cycle take effect on the next cycle.
  - A lone valid source gets `req_ready` in the same cycle; there is no idle-grant delay.

## Configuration
- **`VGA_ARB_BOUNDS_CHECK_EN` defined:**
  - A pixel with x ≥ 160 or y ≥ 120 is still handshaken, so it is accepted and rr/lock update normally.
  - `plot_out` stays 0 for that pixel, and the output data registers hold.
- **Macro not defined:**
  - There is no range check. Every accepted pixel produces `plot_out`=1 with its raw coordinates.
  - The adapter then handles off-screen writes itself.

## Structure
- **Package `vga_pkg`:**
  - Constants `VGA_X_MAX=160` and `VGA_Y_MAX=120`.
  - Colour typedef (3-bit RGB) and constants `BLACK`=3'b000 and `WHITE`=3'b111.
  - State enum `ARB`, `LOCK`.
- **Sub-module `rr_grant`:** combinational, with inputs `valid[N_REQ]` and `ptr`, and output one-hot `grant`. It is reused by later arbiters.

## Test plan
1. **Reset.** Hold `resetn`=0 with all sources valid, then release. Required: while in reset, all outputs are 0 and `req_ready` is 0. On the first cycle after release, source 0 is granted.
2. **Round-robin.** Sources 0, 1, 2 are valid continuously with no lock. Required: accept order 0,1,2,0,1,2, and `plot_out` is high on every cycle from the second onward, with matching x/y.
3. **Lock burst.** Source 1 locks for 5 pixels, (10,10)..(14,10), while 0 and 2 stay valid. Required:
   - Five consecutive plots from source 1.
   - On the final pixel, `req_lock`=0.
   - The next grant is source 2.
4. **Locked stall.** The owner holds `req_lock` but drops valid for 3 cycles. Required: `plot_out`=0 for those cycles, and no other source is granted.
5. **Bounds, macro defined.** Source 0 sends (160,5), then (159,119). Required: both are accepted; `plot_out` is 0 for the first and 1 for the second, with data (159,119).
6. **Reset mid-burst.** Pull `resetn` low while LOCK is active with one pixel in flight. Required: `plot_out` is 0 immediately, and after release the state is ARB with `rr_ptr`=0.
